key_gesture: RTL

Classifies debounced push-button activity into single-click, double-click, long-press and auto-repeat events. Sits directly downstream of the per-key debouncer. It consumes that stage's one-cycle press and release edge pulses and emits one-cycle event pulses to the control FSMs of the top level. One instance per key.

---
 rtl/key_gesture_pkg.sv | 23 ++
 rtl/key_gesture.sv | 122 ++++++++++++
 2 files changed

// File: rtl/key_gesture_pkg.sv
// key_gesture shared types: FSM state encoding and small helpers.
// Imported by the gesture classifier and its bench.
package key_gesture_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    DRAIN  = 3'd3,
    HOLD   = 3'd4
  } kg_state_e;

  function automatic int unsigned max3(
    input int unsigned a,
    input int unsigned b,
    input int unsigned c
  );
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/key_gesture.sv
// key_gesture: turns debounced press/release edges into click,
// double-click, long-press and auto-repeat pulses for one key.
module key_gesture
  import key_gesture_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = 25_000_000,
  parameter int unsigned GAP_CYCLES    = 12_500_000,
  parameter int unsigned REPEAT_CYCLES = 5_000_000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_press,
  input  logic       i_release,
  output logic       o_short,
  output logic       o_double,
  output logic       o_long,
  output logic       o_repeat,
  output logic [2:0] o_state
);

  localparam int unsigned MAXC =
    max3(LONG_CYCLES, GAP_CYCLES, REPEAT_CYCLES);
  localparam int CW = $clog2(MAXC);

  localparam logic [CW-1:0] LONG_T = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] GAP_T  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] REP_T  = CW'(REPEAT_CYCLES - 1);

  generate
    if (LONG_CYCLES < 2 || GAP_CYCLES < 2 ||
        REPEAT_CYCLES < 2) begin : g_bad_param
      $fatal(1, "key_gesture: timing parameters must be >= 2");
    end
  endgenerate

  kg_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          short_d, double_d, long_d, repeat_d;
  logic          press_v, rel_v;

  assign press_v = i_press & ~i_release;
  assign rel_v   = i_release & ~i_press;

  always_comb begin
    state_d  = state_q;
    // Saturate so idle-time counting can never alias a terminal count.
    cnt_d    = (&cnt_q) ? cnt_q : cnt_q + CW'(1);
    short_d  = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (press_v) begin
          state_d = PRESS1;
          cnt_d   = '0;
        end
      end
      PRESS1: begin
        if (rel_v) begin
          state_d = WAIT2;
          cnt_d   = '0;
        end else if (cnt_q == LONG_T) begin
          long_d  = 1'b1;
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      WAIT2: begin
        if (press_v) begin
          double_d = 1'b1;
          state_d  = DRAIN;
          cnt_d    = '0;
        end else if (cnt_q == GAP_T) begin
          short_d = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        if (rel_v) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        if (rel_v) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == REP_T) begin
          repeat_d = 1'b1;
          cnt_d    = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      o_short  <= 1'b0;
      o_double <= 1'b0;
      o_long   <= 1'b0;
      o_repeat <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      o_short  <= short_d;
      o_double <= double_d;
      o_long   <= long_d;
      o_repeat <= repeat_d;
    end
  end

  assign o_state = 3'(state_q);

endmodule
